rom_port_arb: RTL

Arbiter and sequencer for one single-port graphics/program ROM shared by three requesters: the HPS download writer (ioctl stream), the video tile/sprite fetch, and the CPU. Sits inside the game core between the ioctl download path and the ROM array; runs on the core master clock. Fixed-priority scheduling with a CPU anti-starvation guard. Drives the ROM port with a parameterised read latency.

---
 rtl/rom_port_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rom_port_arb.sv
// rom_port_arb: shares one single-port ROM between the download writer,
// the video fetch port and the CPU port. Downloads win, video beats CPU
// except when the CPU has been passed over STARVE times in a row.
module rom_port_arb #(
    parameter int          AW     = 15,
    parameter int          DW     = 8,
    parameter int          RD_LAT = 1,
    parameter logic [24:0] BASE   = 25'h0,
    parameter int          SIZE   = 32768,
    parameter int          STARVE = 4
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          DL_ACTIVE,
    input  logic          DL_WR,
    input  logic [24:0]   DL_AD,
    input  logic [DW-1:0] DL_DT,
    input  logic          VREQ,
    input  logic [AW-1:0] VAD,
    output logic          VACK,
    output logic [DW-1:0] VDT,
    input  logic          CREQ,
    input  logic [AW-1:0] CAD,
    output logic          CACK,
    output logic [DW-1:0] CDT,
    output logic [AW-1:0] MEM_AD,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_DO,
    input  logic [DW-1:0] MEM_DI,
    output logic          BUSY,
    output logic          OVF
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

    localparam int CW = $clog2(RD_LAT + 2);
    localparam int SW = $clog2(STARVE + 2);
    localparam logic [CW-1:0] RD_LAST    = CW'(RD_LAT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [31:0]   LO         = {7'd0, BASE};
    localparam logic [31:0]   HI         = LO + 32'(SIZE);

    state_t          state;
    state_t          state_nxt;
    logic            pend;
    logic [AW-1:0]   hold_addr;
    logic [DW-1:0]   hold_data;
    logic            sel_cpu;
    logic [CW-1:0]   rd_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            dl_hit;
    logic            start_wr;
    logic            grant_v;
    logic            grant_c;
    logic            rd_last;

    assign dl_hit = DL_WR && ({7'd0, DL_AD} >= LO) && ({7'd0, DL_AD} < HI);

    // Next-state decision: pending write first, then reads unless a download is active
    always_comb begin
        state_nxt = state;
        start_wr  = 1'b0;
        grant_v   = 1'b0;
        grant_c   = 1'b0;
        rd_last   = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    start_wr  = 1'b1;
                    state_nxt = WRITE;
                end else if (!DL_ACTIVE) begin
                    if (VREQ && CREQ && starve_cnt == STARVE_MAX) begin
                        grant_c = 1'b1;
                    end else if (VREQ) begin
                        grant_v = 1'b1;
                    end else if (CREQ) begin
                        grant_c = 1'b1;
                    end
                    if (grant_v || grant_c) begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: state_nxt = IDLE;
            READ: begin
                if (rd_cnt == RD_LAST) begin
                    rd_last   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered ROM port, acknowledge pulses and read data capture
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            MEM_AD  <= '0;
            MEM_DO  <= '0;
            MEM_WE  <= 1'b0;
            VACK    <= 1'b0;
            CACK    <= 1'b0;
            VDT     <= '0;
            CDT     <= '0;
            BUSY    <= 1'b0;
            sel_cpu <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            MEM_WE <= start_wr;
            VACK   <= rd_last && !sel_cpu;
            CACK   <= rd_last && sel_cpu;
            BUSY   <= (state_nxt != IDLE);
            if (start_wr) begin
                MEM_AD <= hold_addr;
                MEM_DO <= hold_data;
            end else if (grant_v) begin
                MEM_AD <= VAD;
            end else if (grant_c) begin
                MEM_AD <= CAD;
            end
            if (grant_v || grant_c) begin
                sel_cpu <= grant_c;
                rd_cnt  <= '0;
            end else if (state == READ) begin
                rd_cnt <= rd_cnt + CW'(1);
            end
            if (rd_last) begin
                if (sel_cpu) begin
                    CDT <= MEM_DI;
                end else begin
                    VDT <= MEM_DI;
                end
            end
        end
    end

    // Download holding register; the entry is handed to the write port on the
    // edge that enters WRITE, so a strobe in that cycle or during WRITE is not an overflow
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            pend      <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            OVF       <= 1'b0;
        end else begin
            if (dl_hit) begin
                hold_addr <= AW'(DL_AD - BASE);
                hold_data <= DL_DT;
                pend      <= 1'b1;
                if (pend && !start_wr) begin
                    OVF <= 1'b1;
                end
            end else if (start_wr) begin
                pend <= 1'b0;
            end
        end
    end

    // CPU anti-starvation counter: counts video wins while the CPU is waiting
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (grant_c) begin
            starve_cnt <= '0;
        end else if (state == IDLE && !CREQ) begin
            starve_cnt <= '0;
        end else if (grant_v && CREQ && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule
